// File: rtl/spi_rx_pkg.sv
// Shared constants for the SPI sample receiver: FSM encodings, nibble bit placement, FIFO default.
package spi_rx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;

  // Arrival order I0, I1, Q0, Q1 lands MSB-first in the nibble
  localparam logic [1:0] NIB_I0 = 2'd3;
  localparam logic [1:0] NIB_I1 = 2'd2;
  localparam logic [1:0] NIB_Q0 = 2'd1;
  localparam logic [1:0] NIB_Q1 = 2'd0;

  localparam int DEF_FIFO_DEPTH = 16;

  function automatic logic [1:0] nib_pos(input logic [1:0] cnt);
    case (cnt)
      2'd0:    nib_pos = NIB_I0;
      2'd1:    nib_pos = NIB_I1;
      2'd2:    nib_pos = NIB_Q0;
      default: nib_pos = NIB_Q1;
    endcase
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through byte FIFO; head reads as 8'h00 when empty.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [7:0]    i_wdata,
  input  logic          i_pop,
  output logic [7:0]    o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_free
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_wr, w_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_free  = (AW+1)'(DEPTH) - r_cnt;
  assign o_rdata = o_empty ? 8'h00 : r_mem[r_rd];

  // A push into a full FIFO is still taken when the head leaves in the same cycle
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + AW'(1);
      if (w_rd) r_rd <= r_rd + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr] <= i_wdata;
  end

endmodule

// File: rtl/spi_sample_rx.sv
// SPI slave receiving 2-bit I/Q GPS samples as nibbles, packed in pairs into a byte FIFO.
// Define SPI_SAMPLE_RX_STATS_EN to add the NIBBLE_COUNT completed-nibble counter output.
module spi_sample_rx
  import spi_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_100_000,
  input  logic        RESET,
  input  logic        MCU_SCK,
  input  logic        MCU_SS,
  input  logic        MCU_MOSI,
  output logic        DATAREADY,
  output logic [7:0]  DATA,
  output logic        DATA_VALID,
  input  logic        DATA_READY,
  output logic        OVERFLOW,
  output logic        FRAME_ERR
`ifdef SPI_SAMPLE_RX_STATS_EN
  ,
  output logic [15:0] NIBBLE_COUNT
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_mosi_sync;
  logic       r_sck_prev, r_ss_prev;
  logic [1:0] r_state, r_bitcnt;
  logic [3:0] r_nib, r_hi, w_nib_next;
  logic       r_hi_vld, r_frame_err, r_ovf;
  logic       w_sck, w_ss, w_mosi, w_sck_rise, w_ss_fall, w_ss_rise;
  logic       w_sample, w_nib_done, w_push, w_pop, w_full, w_empty;
  logic [AW:0] w_free;

  // SS idles high so reset leaves no phantom falling edge
  always_ff @(posedge CLK_100_000) begin
    if (RESET) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], MCU_SCK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], MCU_SS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MCU_MOSI};
      r_sck_prev  <= w_sck;
      r_ss_prev   <= w_ss;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_prev;
  assign w_ss_fall  = ~w_ss & r_ss_prev;
  assign w_ss_rise  = w_ss & ~r_ss_prev;

  assign w_sample   = (r_state == ST_SHIFT) & w_sck_rise & ~w_ss;
  assign w_nib_done = w_sample & (r_bitcnt == 2'd3);
  assign w_push     = w_nib_done & r_hi_vld;
  assign w_pop      = DATA_VALID & DATA_READY;

  always_comb begin
    w_nib_next = r_nib;
    w_nib_next[nib_pos(r_bitcnt)] = w_mosi;
  end

  always_ff @(posedge CLK_100_000) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= 2'd0;
      r_nib       <= 4'h0;
      r_hi        <= 4'h0;
      r_hi_vld    <= 1'b0;
      r_frame_err <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_ss_fall) r_state <= ST_SHIFT;
        ST_SHIFT: begin
          if (w_ss_rise) begin
            // The pending high nibble survives; only partial bits are dropped
            r_state     <= ST_IDLE;
            r_bitcnt    <= 2'd0;
            r_frame_err <= (r_bitcnt != 2'd0);
          end else if (w_sample) begin
            r_nib    <= w_nib_next;
            r_bitcnt <= r_bitcnt + 2'd1;
            if (w_nib_done) begin
              r_hi_vld <= ~r_hi_vld;
              if (!r_hi_vld) r_hi <= w_nib_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  sample_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_fifo (
    .i_clk   (CLK_100_000),
    .i_rst   (RESET),
    .i_push  (w_push),
    .i_wdata ({r_hi, w_nib_next}),
    .i_pop   (w_pop),
    .o_rdata (DATA),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_free  (w_free)
  );

  assign DATA_VALID = ~w_empty;
  assign DATAREADY  = ~RESET & (w_free >= (AW+1)'(2));
  assign OVERFLOW   = r_ovf;
  assign FRAME_ERR  = r_frame_err;

`ifdef SPI_SAMPLE_RX_STATS_EN
  logic [15:0] r_nib_cnt;
  always_ff @(posedge CLK_100_000) begin
    if (RESET)           r_nib_cnt <= 16'h0000;
    else if (w_nib_done) r_nib_cnt <= r_nib_cnt + 16'd1;
  end
  assign NIBBLE_COUNT = r_nib_cnt;
`endif

endmodule

// File: doc/spi_sample_rx.md
SPI_SAMPLE_RX -- requirements
Module: spi_sample_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO depth (power of two, 4..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flops in each input synchronizer (2..3).
REQ-003 SHALL have port CLK_100_000 input 1 as the single system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET input 1; synchronous, active-high.
REQ-005 SHALL have port MCU_SCK input 1; SPI serial clock, asynchronous to CLK_100_000.
REQ-006 SHALL have port MCU_SS input 1; SPI slave select, active low, asynchronous.
REQ-007 SHALL have port MCU_MOSI input 1; serial GPS sample bits, asynchronous.
REQ-008 SHALL have port DATAREADY output 1; request to the transmitter for the next nibble.
REQ-009 SHALL have port DATA output 8; FIFO head byte.
REQ-010 SHALL have port DATA_VALID output 1; DATA holds a valid byte.
REQ-011 SHALL have port DATA_READY input 1; consumer accepts DATA.
REQ-012 SHALL have port OVERFLOW output 1; sticky flag, byte dropped.
REQ-013 SHALL have port FRAME_ERR output 1; one-cycle pulse, partial nibble discarded.

Function
REQ-014 SHALL pass MCU_SCK, MCU_SS and MCU_MOSI through SYNC_STAGES-flop synchronizers; CLK_100_000 is at least 4x SCK.
REQ-015 SHALL sample synchronized MOSI on each detected SCK rising edge while synchronized SS is low; edges while SS is high are ignored.
REQ-016 SHALL run FSM IDLE -> SHIFT on SS falling; SHIFT -> IDLE on SS rising; any unused encoding -> IDLE next cycle.
REQ-017 SHALL group every 4 sampled bits into one nibble, in arrival order I0, I1, Q0, Q1, mapped MSB-first into the nibble.
REQ-018 SHALL use a 2-bit bit counter that wraps 3 -> 0 on nibble completion; SS may stay low across several nibbles.
REQ-019 SHALL place the first nibble of a pair in DATA[7:4] and the second in DATA[3:0], then push the byte into the FIFO.
REQ-020 SHALL keep a pending high nibble across SS deassertion; only the bit counter clears on SS rising.
REQ-021 SHALL, on SS rising with bit counter 1..3, discard the partial bits and pulse FRAME_ERR for one cycle.
REQ-022 SHALL make the FIFO first-word-fall-through; a pop occurs when DATA_VALID and DATA_READY are both high.
REQ-023 SHALL, on a push when full, accept it if a pop occurs in the same cycle; otherwise drop the byte and set OVERFLOW.
REQ-024 SHALL drive DATAREADY high when the FIFO has at least 2 free entries and the FSM is not in reset.
REQ-025 SHALL assert DATA_VALID no more than SYNC_STAGES+2 cycles after the raw SCK rising edge carrying the 8th bit of a byte.

Reset
REQ-026 SHALL, while RESET is high, force: FSM IDLE, bit counter 0, pending nibble cleared, FIFO empty, DATA 8'h00, DATA_VALID 0, DATAREADY 0, OVERFLOW 0, FRAME_ERR 0.
REQ-027 SHALL discard any partial nibble or byte when RESET is asserted mid-frame, without pulsing FRAME_ERR.
REQ-028 SHALL, after RESET falls, ignore SCK edges until the first SS falling edge is detected.

Configuration
REQ-029 SHALL, with SPI_SAMPLE_RX_STATS_EN defined, add output NIBBLE_COUNT [15:0]: counts completed nibbles, wraps at 16'hFFFF, clears on RESET.
REQ-030 SHALL, without SPI_SAMPLE_RX_STATS_EN, omit the NIBBLE_COUNT port and its counter entirely.

Structure
REQ-031 SHALL take FSM state encodings, nibble bit positions and the default FIFO depth from shared package spi_rx_pkg.
REQ-032 SHALL implement the FIFO as sub-module sample_fifo (FWFT, full/empty, free-count output).

Verification
REQ-033 SHALL cover two frames with bits 1,0,1,1 then 0,1,0,0 -> one byte 8'hB4 with DATA_VALID within 4 cycles of the last edge.
REQ-034 SHALL cover SS rising after 2 bits -> FRAME_ERR pulses once and no byte is pushed; the next full nibble pair is 8'h?? correct.
REQ-035 SHALL cover DATA_READY held low for 16 bytes -> DATAREADY falls at 15 stored bytes; the 17th byte is dropped and OVERFLOW stays 1.
REQ-036 SHALL cover a full FIFO with a simultaneous push and pop -> count stays 16 and OVERFLOW stays 0.
REQ-037 SHALL cover RESET mid-nibble after 3 bits -> all outputs return to reset values and the next frame decodes cleanly.
REQ-038 SHALL cover, with SPI_SAMPLE_RX_STATS_EN, 6 nibbles -> NIBBLE_COUNT 6; and preload 16'hFFFF plus one nibble -> 0.
